vc_fsm_gen: RTL

Parametrised per-input-VC controller for the router input unit. It is the successor to the fixed 5-port, registered-send VC controller.
- Generalises port count and VC count.
- Adds flit-level flow control in switch traversal (stall when the downstream VC is not ready or the buffer is empty).
- Adds a packet flit counter and an age counter that raises an urgent-priority flag toward the switch allocator.
- One instance per (physical channel, virtual channel) of each input port.

---
 rtl/vc_fsm_gen_pkg.sv | 43 ++++
 rtl/vc_fsm_gen_if.sv | 46 ++++
 rtl/vc_fsm_gen_sel_mux.sv | 52 +++++
 rtl/vc_fsm_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vc_fsm_gen_pkg.sv
// Shared NoC definitions for the per-VC controller: flit type codes, stage codes,
// enable constants and index-width helpers.
package vc_fsm_gen_pkg;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    typedef enum logic [1:0] {
        TYPE_HEAD     = 2'b00,
        TYPE_BODY     = 2'b01,
        TYPE_TAIL     = 2'b10,
        TYPE_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        RC_STAGE  = 2'b00,
        VSA_STAGE = 2'b01,
        ST_STAGE  = 2'b10
    } stage_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Select fields never shrink to zero bits, even for a single port or VC.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic logic is_head(input flit_type_e t);
        return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_fsm_gen_if.sv
// Input-unit <-> VC controller bundle. Optional macro VC_MULTAB_EN adds multab_en.
interface vc_fsm_gen_if
    import vc_fsm_gen_pkg::*;
#(
    parameter int NPORT = 5,
    parameter int NVCH  = 2,
    parameter int FLITW = 34,
    parameter int CNT_W = 8,
    localparam int PORT_W = idx_w(NPORT),
    localparam int VCH_W  = idx_w(NVCH)
);

    logic [FLITW-1:0]      bdata;
    logic                  bvalid;
    logic [PORT_W-1:0]     port;
    logic [VCH_W-1:0]      ovch;
    logic [NPORT*NVCH-1:0] irdy_vec;
    logic [NPORT*NVCH-1:0] ilck_vec;
    logic [NPORT-1:0]      grt_vec;
`ifdef VC_MULTAB_EN
    logic                  multab_en;
`endif
    logic                  req;
    logic                  send;
    logic                  olck;
    logic                  urgent;
    logic [CNT_W-1:0]      flit_cnt;
    logic                  port_err;

    modport master (
        output bdata, bvalid, port, ovch, irdy_vec, ilck_vec, grt_vec,
`ifdef VC_MULTAB_EN
        output multab_en,
`endif
        input  req, send, olck, urgent, flit_cnt, port_err
    );

    modport slave (
        input  bdata, bvalid, port, ovch, irdy_vec, ilck_vec, grt_vec,
`ifdef VC_MULTAB_EN
        input  multab_en,
`endif
        output req, send, olck, urgent, flit_cnt, port_err
    );

endinterface

// File: rtl/vc_fsm_gen_sel_mux.sv
// Picks ilck/irdy/grt for the routed (port, ovch); out-of-range selects read as locked.
// Optional macro VC_MULTAB_EN also folds in the lock of the local/ejection VC.
module vc_fsm_gen_sel_mux
    import vc_fsm_gen_pkg::*;
#(
    parameter int NPORT = 5,
    parameter int NVCH  = 2,
    localparam int PORT_W = idx_w(NPORT),
    localparam int VCH_W  = idx_w(NVCH)
) (
    input  logic [PORT_W-1:0]     port_i,
    input  logic [VCH_W-1:0]      ovch_i,
    input  logic [NPORT*NVCH-1:0] irdy_vec_i,
    input  logic [NPORT*NVCH-1:0] ilck_vec_i,
    input  logic [NPORT-1:0]      grt_vec_i,
`ifdef VC_MULTAB_EN
    input  logic                  multab_en_i,
`endif
    output logic                  ilck_o,
    output logic                  irdy_o,
    output logic                  grt_o,
    output logic                  port_ok_o
);

    always_comb begin
        ilck_o    = 1'b1;
        irdy_o    = 1'b0;
        grt_o     = 1'b0;
        port_ok_o = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (port_i == PORT_W'(p)) begin
                port_ok_o = 1'b1;
                grt_o     = grt_vec_i[p];
                for (int v = 0; v < NVCH; v++) begin
                    if (ovch_i == VCH_W'(v)) begin
                        ilck_o = ilck_vec_i[p*NVCH+v];
                        irdy_o = irdy_vec_i[p*NVCH+v];
                    end
                end
            end
        end
`ifdef VC_MULTAB_EN
        // A multicast hit also needs the same VC on the last (local) port to be free.
        for (int v = 0; v < NVCH; v++) begin
            if (multab_en_i && (ovch_i == VCH_W'(v))) begin
                ilck_o = ilck_o | ilck_vec_i[(NPORT-1)*NVCH+v];
            end
        end
`endif
    end

endmodule

// File: rtl/vc_fsm_gen.sv
// Per-input-VC router controller: RC -> VSA -> ST with flit-level flow control,
// flit counter and VSA age/urgent hint. Optional macro VC_MULTAB_EN enables multab_en.
module vc_fsm_gen
    import vc_fsm_gen_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int VCHID    = 0,
    parameter int NPORT    = 5,
    parameter int NVCH     = 2,
    parameter int FLITW    = 34,
    parameter int TYPE_LSB = 32,
    parameter int AGE_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_,
    vc_fsm_gen_if.slave bus
);

    localparam int unused_ids = ROUTERID + PCHID + VCHID;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    stage_e           state_q, state_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;

    logic       ilck, irdy, grt, port_ok;
    logic       req_c, send_c;
    flit_type_e ftype;
    logic       unused_bits;

    assign ftype       = flit_type_e'(bus.bdata[TYPE_LSB+1:TYPE_LSB]);
    assign unused_bits = ^bus.bdata;

    vc_fsm_gen_sel_mux #(
        .NPORT (NPORT),
        .NVCH  (NVCH)
    ) u_sel (
        .port_i      (bus.port),
        .ovch_i      (bus.ovch),
        .irdy_vec_i  (bus.irdy_vec),
        .ilck_vec_i  (bus.ilck_vec),
        .grt_vec_i   (bus.grt_vec),
`ifdef VC_MULTAB_EN
        .multab_en_i (bus.multab_en),
`endif
        .ilck_o      (ilck),
        .irdy_o      (irdy),
        .grt_o       (grt),
        .port_ok_o   (port_ok)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= RC_STAGE;
            age_q   <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        unique case (state_q)
            RC_STAGE: begin
                if (bus.bvalid && is_head(ftype)) begin
                    state_d = VSA_STAGE;
                    perr_d  = !port_ok;
                    cnt_d   = '0;
                    age_d   = '0;
                end
            end
            VSA_STAGE: begin
                if (send_c) begin
                    cnt_d   = CNT_W'(1);
                    age_d   = '0;
                    state_d = is_tail(ftype) ? RC_STAGE : ST_STAGE;
                end else begin
                    age_d = age_sat_inc(age_q);
                end
            end
            ST_STAGE: begin
                if (send_c) begin
                    cnt_d = cnt_sat_inc(cnt_q);
                    if (is_tail(ftype)) state_d = RC_STAGE;
                end
            end
            default: state_d = RC_STAGE;
        endcase
    end

    // ST ignores ilck: the lock on the output VC is held by this VC.
    always_comb begin
        req_c  = 1'b0;
        send_c = 1'b0;
        unique case (state_q)
            VSA_STAGE: begin
                req_c  = !ilck;
                send_c = bus.bvalid && !ilck && grt && irdy;
            end
            ST_STAGE: begin
                req_c  = bus.bvalid;
                send_c = bus.bvalid && grt && irdy;
            end
            default: ;
        endcase
    end

    assign bus.req      = req_c;
    assign bus.send     = send_c;
    assign bus.olck     = (state_q != RC_STAGE);
    assign bus.urgent   = (state_q == VSA_STAGE) && (age_q == AGE_MAX);
    assign bus.flit_cnt = cnt_q;
    assign bus.port_err = perr_q;

    rc_head_only: assert property (@(posedge clk) disable iff (!rst_)
        (state_q == RC_STAGE && bus.bvalid) |-> is_head(ftype));

endmodule
